// File: rtl/icache_sa_if.sv
// Fetch/memory bus bundle for icache_sa.
//   Fetch side : req_valid, req_addr, req_ready, flush, inst_valid, inst_out, miss_pulse
//   Memory side: mem_req_valid, mem_req_addr, mem_resp_valid, mem_resp_data
// slave  = cache view, master = fetch unit + memory controller view.
interface icache_sa_if;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_ready;
    logic        flush;
    logic        inst_valid;
    logic [31:0] inst_out;
    logic        miss_pulse;
    logic        mem_req_valid;
    logic [31:0] mem_req_addr;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;

    modport slave (
        input  req_valid, req_addr, flush, mem_resp_valid, mem_resp_data,
        output req_ready, inst_valid, inst_out, miss_pulse, mem_req_valid, mem_req_addr
    );

    modport master (
        output req_valid, req_addr, flush, mem_resp_valid, mem_resp_data,
        input  req_ready, inst_valid, inst_out, miss_pulse, mem_req_valid, mem_req_addr
    );
endinterface

// File: rtl/icache_sa.sv
// Two-way set-associative instruction cache with multi-word lines.
// Ports:
//   clk_in  - clock
//   rst_in  - asynchronous active-high reset
//   rdy_in  - global ready; low freezes every register and the storage
//   bus     - icache_sa_if.slave: fetch request/response, flush, miss pulse,
//             and the one-outstanding word-read handshake to memory
// A fetch is accepted in IDLE, tag-checked in LOOKUP, and on a miss the whole
// line is read word by word in REFILL. A flush during REFILL with a request in
// flight parks in DRAIN until that response arrives and is dropped.
module icache_sa #(
    parameter int INDEX_W  = 4,
    parameter int OFFSET_W = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    icache_sa_if.slave  bus
);
    localparam int TAG_W = 30 - INDEX_W - OFFSET_W;
    localparam int SETS  = 1 << INDEX_W;
    localparam int LINES = SETS << OFFSET_W;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOOKUP = 2'd1;
    localparam logic [1:0] S_REFILL = 2'd2;
    localparam logic [1:0] S_DRAIN  = 2'd3;

    logic [1:0]          state;
    logic [29:0]         waddr_q;      // latched word address of the fetch
    logic [TAG_W-1:0]    tag_q;
    logic [INDEX_W-1:0]  idx_q;
    logic [OFFSET_W-1:0] off_q;

    logic [SETS-1:0]     valid0, valid1;
    logic [SETS-1:0]     lru;          // way to evict next when both ways valid
    logic [TAG_W-1:0]    tag0 [SETS];
    logic [TAG_W-1:0]    tag1 [SETS];
    logic [31:0]         data0 [LINES];
    logic [31:0]         data1 [LINES];

    logic                victim;
    logic [OFFSET_W-1:0] cnt;
    logic [31:0]         cap;          // requested word captured during refill

    logic hit0, hit1, victim_sel, last, wr_en;

    assign tag_q = waddr_q[29:OFFSET_W+INDEX_W];
    assign idx_q = waddr_q[OFFSET_W+INDEX_W-1:OFFSET_W];
    assign off_q = waddr_q[OFFSET_W-1:0];

    assign hit0 = valid0[idx_q] && (tag0[idx_q] == tag_q);
    assign hit1 = valid1[idx_q] && (tag1[idx_q] == tag_q);

    // Fill an empty way first; only fall back to LRU when the set is full.
    assign victim_sel = !valid0[idx_q] ? 1'b0 :
                        !valid1[idx_q] ? 1'b1 : lru[idx_q];

    assign last  = (cnt == {OFFSET_W{1'b1}});
    assign wr_en = rdy_in && (state == S_REFILL) && !bus.flush && bus.mem_resp_valid;

    // Gated by reset and rdy_in so a visible ready always means the edge accepts.
    assign bus.req_ready = !rst_in && rdy_in && (state == S_IDLE) && !bus.flush;

    // Datapath storage: not reset, qualified by valid bits and state.
    always_ff @(posedge clk_in) begin
        if (rdy_in) begin
            if (bus.req_valid && bus.req_ready)
                waddr_q <= bus.req_addr[31:2];
            if (wr_en) begin
                if (victim)
                    data1[{idx_q, cnt}] <= bus.mem_resp_data;
                else
                    data0[{idx_q, cnt}] <= bus.mem_resp_data;
                if (cnt == off_q)
                    cap <= bus.mem_resp_data;
                if (last) begin
                    if (victim)
                        tag1[idx_q] <= tag_q;
                    else
                        tag0[idx_q] <= tag_q;
                end
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state             <= S_IDLE;
            valid0            <= '0;
            valid1            <= '0;
            lru               <= '0;
            victim            <= 1'b0;
            cnt               <= '0;
            bus.inst_valid    <= 1'b0;
            bus.inst_out      <= '0;
            bus.miss_pulse    <= 1'b0;
            bus.mem_req_valid <= 1'b0;
            bus.mem_req_addr  <= '0;
        end else if (rdy_in) begin
            bus.inst_valid <= 1'b0;
            bus.miss_pulse <= 1'b0;

            // DRAIN is entered only after a flush, so nothing is valid there.
            if (bus.flush && state != S_DRAIN) begin
                valid0 <= '0;
                valid1 <= '0;
            end

            case (state)
                S_IDLE: begin
                    if (bus.req_valid && bus.req_ready)
                        state <= S_LOOKUP;
                end

                S_LOOKUP: begin
                    if (bus.flush) begin
                        state <= S_IDLE;
                    end else if (hit0 || hit1) begin
                        bus.inst_valid <= 1'b1;
                        bus.inst_out   <= hit1 ? data1[{idx_q, off_q}] : data0[{idx_q, off_q}];
                        lru[idx_q]     <= ~hit1;
                        state          <= S_IDLE;
                    end else begin
                        bus.miss_pulse    <= 1'b1;
                        victim            <= victim_sel;
                        cnt               <= '0;
                        bus.mem_req_valid <= 1'b1;
                        bus.mem_req_addr  <= {tag_q, idx_q, {(OFFSET_W+2){1'b0}}};
                        state             <= S_REFILL;
                    end
                end

                S_REFILL: begin
                    if (bus.flush) begin
                        // A response on this very edge settles the request.
                        bus.mem_req_valid <= 1'b0;
                        state <= bus.mem_resp_valid ? S_IDLE : S_DRAIN;
                    end else if (bus.mem_resp_valid) begin
                        if (last) begin
                            bus.mem_req_valid <= 1'b0;
                            if (victim)
                                valid1[idx_q] <= 1'b1;
                            else
                                valid0[idx_q] <= 1'b1;
                            lru[idx_q]     <= ~victim;
                            bus.inst_valid <= 1'b1;
                            bus.inst_out   <= (cnt == off_q) ? bus.mem_resp_data : cap;
                            state          <= S_IDLE;
                        end else begin
                            cnt              <= cnt + 1'b1;
                            bus.mem_req_addr <= bus.mem_req_addr + 32'd4;
                        end
                    end
                end

                S_DRAIN: begin
                    if (bus.mem_resp_valid)
                        state <= S_IDLE;
                end

                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_icache_sa.sv
// Self-checking bench for icache_sa: directed scenarios plus randomized
// fetch/flush traffic against a per-set recency-list reference model.
module tb_icache_sa;
    logic clk_in = 1'b0;
    logic rst_in;
    logic rdy_in;

    icache_sa_if bus();

    icache_sa dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .rdy_in (rdy_in),
        .bus    (bus.slave)
    );

    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_pass   = 0;

    // ---------------- memory controller model ----------------
    logic [31:0] req_log [$];
    int          resp_cnt = 0;
    logic        consumed = 1'b0;
    logic        outst    = 1'b0;
    logic [31:0] oaddr    = '0;
    int          lat_cnt  = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a[31:4] == 28'h0000100)
            return 32'hA0 + 32'(a[3:2]);
        return {a[15:0] ^ 16'hC3A5, a[15:0]};
    endfunction

    always @(posedge clk_in) begin
        consumed <= bus.mem_resp_valid && rdy_in && !rst_in;
        if (bus.mem_resp_valid && rdy_in && !rst_in)
            resp_cnt <= resp_cnt + 1;
    end

    always @(negedge clk_in) begin
        if (rst_in) begin
            bus.mem_resp_valid <= 1'b0;
            bus.mem_resp_data  <= '0;
            outst              <= 1'b0;
            lat_cnt            <= 0;
        end else if (consumed) begin
            bus.mem_resp_valid <= 1'b0;
            if (bus.mem_req_valid) begin
                outst   <= 1'b1;
                oaddr   <= bus.mem_req_addr;
                req_log.push_back(bus.mem_req_addr);
                lat_cnt <= int'($urandom_range(0, 2));
            end else begin
                outst <= 1'b0;
            end
        end else if (!outst && bus.mem_req_valid) begin
            outst   <= 1'b1;
            oaddr   <= bus.mem_req_addr;
            req_log.push_back(bus.mem_req_addr);
            lat_cnt <= int'($urandom_range(0, 2));
        end else if (outst && !bus.mem_resp_valid) begin
            if (lat_cnt == 0) begin
                bus.mem_resp_valid <= 1'b1;
                bus.mem_resp_data  <= mem_word(oaddr);
            end else begin
                lat_cnt <= lat_cnt - 1;
            end
        end
    end

    // ---------------- reference model: per-set recency list of line bases ----------------
    logic [31:0] model_sets [16][$];

    function automatic void model_clear();
        for (int s = 0; s < 16; s++) model_sets[s].delete();
    endfunction

    function automatic bit model_access(input logic [31:0] a);
        int          s;
        int          found;
        logic [31:0] base;
        s     = int'(a[7:4]);
        base  = {a[31:4], 4'h0};
        found = -1;
        for (int i = 0; i < model_sets[s].size(); i++)
            if (model_sets[s][i] == base) found = i;
        if (found >= 0) begin
            model_sets[s].delete(found);
            model_sets[s].push_back(base);
            return 1'b1;
        end
        if (model_sets[s].size() >= 2) model_sets[s].delete(0);
        model_sets[s].push_back(base);
        return 1'b0;
    endfunction

    // ---------------- drivers ----------------
    task automatic reset_dut();
        @(negedge clk_in);
        rst_in = 1'b1; rdy_in = 1'b1; bus.flush = 1'b0; bus.req_valid = 1'b0; bus.req_addr = '0;
        repeat (2) @(negedge clk_in);
        #1 rst_in = 1'b0;
        model_clear();
    endtask

    // Drives a request and returns right after the accepting posedge.
    task automatic start_req(input logic [31:0] a, output bit ok);
        int n;
        @(negedge clk_in);
        bus.req_valid = 1'b1; bus.req_addr = a;
        #1;
        n = 0;
        while (bus.req_ready !== 1'b1 && n < 50) begin
            @(negedge clk_in); #1; n++;
        end
        ok = (bus.req_ready === 1'b1);
        if (!ok) begin
            bus.req_valid = 1'b0;
            return;
        end
        @(posedge clk_in);
    endtask

    // lat counts cycles from the accept cycle (accept = cycle 0).
    task automatic wait_inst(output logic [31:0] d, output int lat, output int nmiss, output bit ok);
        @(negedge clk_in); #1;
        bus.req_valid = 1'b0;
        lat = 1; nmiss = 0; d = '0; ok = 1'b0;
        if (bus.miss_pulse === 1'b1) nmiss++;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk_in); #1;
            lat++;
            if (bus.miss_pulse === 1'b1) nmiss++;
            if (bus.inst_valid === 1'b1) begin
                d  = bus.inst_out;
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_fetch(input logic [31:0] a, output logic [31:0] d, output int lat,
                            output int nmiss, output int nreq, output bit ok);
        int q0;
        q0 = req_log.size();
        d = '0; lat = 0; nmiss = 0; nreq = 0;
        start_req(a, ok);
        if (!ok) return;
        wait_inst(d, lat, nmiss, ok);
        nreq = req_log.size() - q0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        @(negedge clk_in);
        rst_in = 1'b1;
        #1;
        n_checks++; if (bus.req_ready !== 1'b0) $display("FAIL reset_req_ready: got %b want 0", bus.req_ready); else n_pass++;
        n_checks++; if (bus.inst_valid !== 1'b0) $display("FAIL reset_inst_valid: got %b want 0", bus.inst_valid); else n_pass++;
        n_checks++; if (bus.inst_out !== 32'h0) $display("FAIL reset_inst_out: got %h want 0", bus.inst_out); else n_pass++;
        n_checks++; if (bus.mem_req_valid !== 1'b0) $display("FAIL reset_mem_req_valid: got %b want 0", bus.mem_req_valid); else n_pass++;
        n_checks++; if (bus.mem_req_addr !== 32'h0) $display("FAIL reset_mem_req_addr: got %h want 0", bus.mem_req_addr); else n_pass++;
        n_checks++; if (bus.miss_pulse !== 1'b0) $display("FAIL reset_miss_pulse: got %b want 0", bus.miss_pulse); else n_pass++;
        repeat (2) @(negedge clk_in);
        #1 rst_in = 1'b0;
        #1;
        n_checks++; if (bus.req_ready !== 1'b1) $display("FAIL idle_req_ready: got %b want 1", bus.req_ready); else n_pass++;
        model_clear();
    endtask

    task automatic test_miss_then_hit();
        logic [31:0] d; int lat, nmiss, nreq, q0; bit ok;
        reset_dut();
        q0 = req_log.size();
        do_fetch(32'h0000_1000, d, lat, nmiss, nreq, ok);
        n_checks++; if (ok !== 1'b1) $display("FAIL miss_done: got %b want 1", ok); else n_pass++;
        n_checks++; if (nmiss != 1) $display("FAIL miss_pulses: got %0d want 1", nmiss); else n_pass++;
        n_checks++; if (nreq != 4) $display("FAIL miss_nreq: got %0d want 4", nreq); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            if (q0 + i < req_log.size()) begin
                n_checks++;
                if (req_log[q0+i] !== 32'h1000 + 32'(4*i))
                    $display("FAIL miss_addr%0d: got %h want %h", i, req_log[q0+i], 32'h1000 + 32'(4*i));
                else n_pass++;
            end
        end
        n_checks++; if (d !== 32'hA0) $display("FAIL miss_data: got %h want 000000a0", d); else n_pass++;
        @(negedge clk_in); #1;
        n_checks++; if (bus.inst_valid !== 1'b0) $display("FAIL inst_valid_pulse: got %b want 0", bus.inst_valid); else n_pass++;
        void'(model_access(32'h1000));
        do_fetch(32'h0000_1008, d, lat, nmiss, nreq, ok);
        n_checks++; if (ok !== 1'b1) $display("FAIL hit_done: got %b want 1", ok); else n_pass++;
        n_checks++; if (lat != 2) $display("FAIL hit_latency: got %0d want 2", lat); else n_pass++;
        n_checks++; if (d !== 32'hA2) $display("FAIL hit_data: got %h want 000000a2", d); else n_pass++;
        n_checks++; if (nreq != 0 || nmiss != 0) $display("FAIL hit_no_mem: got req=%0d miss=%0d want 0/0", nreq, nmiss); else n_pass++;
    endtask

    task automatic test_lru();
        logic [31:0] addrs [6];
        bit          hits  [6];
        logic [31:0] d; int lat, nmiss, nreq; bit ok;
        addrs = '{32'h1000, 32'h2000, 32'h1000, 32'h3000, 32'h1000, 32'h2000};
        hits  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        reset_dut();
        for (int i = 0; i < 6; i++) begin
            do_fetch(addrs[i], d, lat, nmiss, nreq, ok);
            n_checks++;
            if (ok !== 1'b1 || nmiss != (hits[i] ? 0 : 1))
                $display("FAIL lru_step%0d: got ok=%b miss=%0d want ok=1 miss=%0d", i, ok, nmiss, hits[i] ? 0 : 1);
            else n_pass++;
            n_checks++;
            if (d !== mem_word(addrs[i])) $display("FAIL lru_data%0d: got %h want %h", i, d, mem_word(addrs[i]));
            else n_pass++;
        end
    endtask

    task automatic test_flush_refill();
        logic [31:0] d; int lat, nmiss, nreq, q0, r0, n; bit ok, seen_iv;
        reset_dut();
        q0 = req_log.size(); r0 = resp_cnt;
        start_req(32'h1000, ok);
        @(negedge clk_in); #1; bus.req_valid = 1'b0;
        n = 0;
        while (!((resp_cnt - r0) == 2 && bus.mem_req_valid === 1'b1) && n < 100) begin
            @(negedge clk_in); #1; n++;
        end
        n_checks++; if (n >= 100) $display("FAIL flush_reach_third_req: got timeout want reached"); else n_pass++;
        bus.flush = 1'b1;
        @(negedge clk_in); #1;
        bus.flush = 1'b0;
        seen_iv = 1'b0; n = 0;
        while (bus.req_ready !== 1'b1 && n < 100) begin
            if (bus.inst_valid === 1'b1) seen_iv = 1'b1;
            @(negedge clk_in); #1; n++;
        end
        if (bus.inst_valid === 1'b1) seen_iv = 1'b1;
        n_checks++; if (bus.req_ready !== 1'b1) $display("FAIL flush_ready_back: got %b want 1", bus.req_ready); else n_pass++;
        n_checks++; if (seen_iv !== 1'b0) $display("FAIL flush_no_inst: got %b want 0", seen_iv); else n_pass++;
        repeat (3) @(negedge clk_in); #1;
        n_checks++; if ((resp_cnt - r0) != 3) $display("FAIL flush_resp_count: got %0d want 3", resp_cnt - r0); else n_pass++;
        n_checks++; if ((req_log.size() - q0) != 3) $display("FAIL flush_req_count: got %0d want 3", req_log.size() - q0); else n_pass++;
        n_checks++; if (bus.mem_req_valid !== 1'b0) $display("FAIL flush_req_dropped: got %b want 0", bus.mem_req_valid); else n_pass++;
        model_clear();
        q0 = req_log.size();
        do_fetch(32'h1000, d, lat, nmiss, nreq, ok);
        n_checks++;
        if (ok !== 1'b1 || nmiss != 1 || nreq != 4) $display("FAIL flush_refetch: got ok=%b miss=%0d req=%0d want 1/1/4", ok, nmiss, nreq);
        else n_pass++;
        n_checks++;
        if (req_log.size() < q0 + 1 || req_log[q0] !== 32'h1000)
            $display("FAIL flush_refetch_base: got %h want 00001000", (req_log.size() > q0) ? req_log[q0] : 32'hFFFF_FFFF);
        else n_pass++;
        n_checks++; if (d !== 32'hA0) $display("FAIL flush_refetch_data: got %h want 000000a0", d); else n_pass++;
    endtask

    task automatic test_stall();
        logic [31:0] d, a0; int lat, nmiss, q0, r0, n; bit ok, stable;
        reset_dut();
        q0 = req_log.size(); r0 = resp_cnt;
        start_req(32'h1000, ok);
        n = 0;
        @(negedge clk_in); #1; bus.req_valid = 1'b0;
        while (!((resp_cnt - r0) == 1 && bus.mem_resp_valid === 1'b1) && n < 100) begin
            @(negedge clk_in); #1; n++;
        end
        rdy_in = 1'b0;
        a0 = bus.mem_req_addr;
        n_checks++; if (a0 !== 32'h1004) $display("FAIL stall_addr_before: got %h want 00001004", a0); else n_pass++;
        stable = 1'b1;
        repeat (5) begin
            @(negedge clk_in); #1;
            if (bus.mem_req_addr !== a0 || bus.mem_req_valid !== 1'b1 || bus.inst_valid !== 1'b0 ||
                bus.req_ready !== 1'b0 || (resp_cnt - r0) != 1)
                stable = 1'b0;
        end
        n_checks++; if (stable !== 1'b1) $display("FAIL stall_frozen: got %b want 1", stable); else n_pass++;
        rdy_in = 1'b1;
        wait_inst(d, lat, nmiss, ok);
        n_checks++; if (ok !== 1'b1 || d !== 32'hA0) $display("FAIL stall_data: got ok=%b %h want 1/000000a0", ok, d); else n_pass++;
        n_checks++; if ((req_log.size() - q0) != 4) $display("FAIL stall_req_count: got %0d want 4", req_log.size() - q0); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            if (q0 + i < req_log.size()) begin
                n_checks++;
                if (req_log[q0+i] !== 32'h1000 + 32'(4*i))
                    $display("FAIL stall_addr%0d: got %h want %h", i, req_log[q0+i], 32'h1000 + 32'(4*i));
                else n_pass++;
            end
        end
    endtask

    task automatic test_async_reset();
        logic [31:0] d; int lat, nmiss, nreq, n; bit ok;
        reset_dut();
        do_fetch(32'h1000, d, lat, nmiss, nreq, ok);
        do_fetch(32'h1000, d, lat, nmiss, nreq, ok);
        n_checks++; if (ok !== 1'b1 || nmiss != 0) $display("FAIL arst_prehit: got ok=%b miss=%0d want 1/0", ok, nmiss); else n_pass++;
        start_req(32'h2000, ok);
        @(negedge clk_in); #1; bus.req_valid = 1'b0;
        n = 0;
        while (bus.mem_req_valid !== 1'b1 && n < 50) begin
            @(negedge clk_in); #1; n++;
        end
        n_checks++; if (bus.mem_req_valid !== 1'b1) $display("FAIL arst_in_refill: got %b want 1", bus.mem_req_valid); else n_pass++;
        #1 rst_in = 1'b1;
        #1;
        n_checks++; if (bus.mem_req_valid !== 1'b0) $display("FAIL arst_mem_req_valid: got %b want 0", bus.mem_req_valid); else n_pass++;
        n_checks++; if (bus.inst_valid !== 1'b0) $display("FAIL arst_inst_valid: got %b want 0", bus.inst_valid); else n_pass++;
        n_checks++; if (bus.req_ready !== 1'b0) $display("FAIL arst_req_ready: got %b want 0", bus.req_ready); else n_pass++;
        repeat (2) @(negedge clk_in);
        #1 rst_in = 1'b0;
        model_clear();
        do_fetch(32'h1000, d, lat, nmiss, nreq, ok);
        n_checks++; if (ok !== 1'b1 || nmiss != 1) $display("FAIL arst_former_hit_misses: got ok=%b miss=%0d want 1/1", ok, nmiss); else n_pass++;
        n_checks++; if (d !== 32'hA0) $display("FAIL arst_refetch_data: got %h want 000000a0", d); else n_pass++;
    endtask

    task automatic test_flush_vs_req();
        logic [31:0] d; int lat, nmiss, nreq; bit ok;
        reset_dut();
        do_fetch(32'h4000, d, lat, nmiss, nreq, ok);
        @(negedge clk_in); #1;
        bus.flush = 1'b1; bus.req_valid = 1'b1; bus.req_addr = 32'h4000;
        #1;
        n_checks++; if (bus.req_ready !== 1'b0) $display("FAIL fvr_ready_during_flush: got %b want 0", bus.req_ready); else n_pass++;
        @(negedge clk_in); #1;
        bus.flush = 1'b0;
        #1;
        n_checks++; if (bus.req_ready !== 1'b1) $display("FAIL fvr_ready_after_flush: got %b want 1", bus.req_ready); else n_pass++;
        @(posedge clk_in);
        wait_inst(d, lat, nmiss, ok);
        n_checks++; if (ok !== 1'b1 || nmiss != 1) $display("FAIL fvr_held_req_misses: got ok=%b miss=%0d want 1/1", ok, nmiss); else n_pass++;
        n_checks++; if (d !== mem_word(32'h4000)) $display("FAIL fvr_data: got %h want %h", d, mem_word(32'h4000)); else n_pass++;
    endtask

    task automatic test_random();
        logic [31:0] a, d; int lat, nmiss, nreq; bit ok, exp_hit;
        reset_dut();
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 7) == 0) begin
                @(negedge clk_in); #1; bus.flush = 1'b1;
                @(negedge clk_in); #1; bus.flush = 1'b0;
                model_clear();
            end
            a = (32'($urandom_range(1, 4)) << 12) | (32'($urandom_range(0, 1)) << 4) | (32'($urandom_range(0, 3)) << 2);
            exp_hit = model_access(a);
            do_fetch(a, d, lat, nmiss, nreq, ok);
            n_checks++; if (ok !== 1'b1) $display("FAIL rnd%0d_done: got %b want 1", it, ok); else n_pass++;
            n_checks++; if (d !== mem_word(a)) $display("FAIL rnd%0d_data: addr %h got %h want %h", it, a, d, mem_word(a)); else n_pass++;
            n_checks++; if (nmiss != (exp_hit ? 0 : 1)) $display("FAIL rnd%0d_miss: addr %h got %0d want %0d", it, a, nmiss, exp_hit ? 0 : 1); else n_pass++;
            n_checks++; if (nreq != (exp_hit ? 0 : 4)) $display("FAIL rnd%0d_nreq: addr %h got %0d want %0d", it, a, nreq, exp_hit ? 0 : 4); else n_pass++;
            @(negedge clk_in); #1;
            n_checks++;
            if (bus.inst_valid !== 1'b0 || bus.miss_pulse !== 1'b0)
                $display("FAIL rnd%0d_pulse_width: got iv=%b mp=%b want 0/0", it, bus.inst_valid, bus.miss_pulse);
            else n_pass++;
        end
    endtask

    initial begin
        rst_in = 1'b1; rdy_in = 1'b1;
        bus.flush = 1'b0; bus.req_valid = 1'b0; bus.req_addr = '0;
        test_reset();
        test_miss_then_hit();
        test_lru();
        test_flush_refill();
        test_stall();
        test_async_reset();
        test_flush_vs_req();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "bench did not complete");
    end
endmodule
